unsort: RTL

UNSORT -- requirements
Module: unsort

---
 rtl/jls_pkg.sv | 12 +
 rtl/unsort_if.sv | 31 +++
 rtl/lane_gather.sv | 13 +
 rtl/unsort.sv | 74 +++++++
 4 files changed

// File: rtl/jls_pkg.sv
// jls_pkg: shared slot/lane geometry and slot payload type for the scatter/gather blocks.
package jls_pkg;
  localparam int NSLOT = 14;
  localparam int NLANE = 8;
  localparam logic [3:0] QL_NONE = 4'hf;
  typedef struct packed {
    logic [7:0] x;
    logic [7:0] px;
    logic       s;
    logic [4:0] qh;
  } slot_t;
endpackage

// File: rtl/unsort_if.sv
// unsort_if: slot-side input beat and lane-side output beat of the unsort gather.
interface unsort_if import jls_pkg::*; #(parameter int ERRW = 16);
  logic            i_et;
  logic            o_rdy;
  logic            i_vl [0:NSLOT-1];
  logic [7:0]      i_x  [0:NSLOT-1];
  logic [7:0]      i_px [0:NSLOT-1];
  logic            i_s  [0:NSLOT-1];
  logic [4:0]      i_qh [0:NSLOT-1];
  logic [3:0]      i_ql [1:NLANE];
  logic [13:0]     i_rl;
  logic            o_et;
  logic            i_rdy;
  logic            o_vl [1:NLANE];
  logic [7:0]      o_x  [1:NLANE];
  logic [7:0]      o_px [1:NLANE];
  logic            o_s  [1:NLANE];
  logic [4:0]      o_qh [1:NLANE];
  logic [3:0]      o_ql [1:NLANE];
  logic [13:0]     o_rl;
  logic            o_err;
  logic [ERRW-1:0] o_err_cnt;
  modport slave (
    input  i_et, i_vl, i_x, i_px, i_s, i_qh, i_ql, i_rl, i_rdy,
    output o_rdy, o_et, o_vl, o_x, o_px, o_s, o_qh, o_ql, o_rl, o_err, o_err_cnt
  );
  modport master (
    output i_et, i_vl, i_x, i_px, i_s, i_qh, i_ql, i_rl, i_rdy,
    input  o_rdy, o_et, o_vl, o_x, o_px, o_s, o_qh, o_ql, o_rl, o_err, o_err_cnt
  );
endinterface

// File: rtl/lane_gather.sv
// lane_gather: picks one slot for a lane; an out-of-range selector yields an empty, zeroed lane.
module lane_gather import jls_pkg::*; (
  input  slot_t      sl [0:NSLOT-1],
  input  logic       vl [0:NSLOT-1],
  input  logic [3:0] sel,
  output slot_t      o,
  output logic       v
);
  logic e;
  assign e = sel < 4'(NSLOT);
  assign o = e ? sl[sel] : '0;
  assign v = e & vl[sel];
endmodule

// File: rtl/unsort.sv
// unsort: two-stage gather of 14 scattered slots back into 8 ordered lanes with map-error tracking.
module unsort import jls_pkg::*; #(parameter int ERRW = 16) (
  input logic clk,
  input logic rst,
  unsort_if.slave bus
);
  logic            a_v;
  logic            a_vl [0:NSLOT-1];
  slot_t           a_sl [0:NSLOT-1];
  logic [3:0]      a_ql [1:NLANE];
  logic [13:0]     a_rl;
  logic            a_adv, b_adv, err;
  slot_t           g_sl [1:NLANE];
  logic            g_v  [1:NLANE];
  logic [ERRW-1:0] cnt;
  assign b_adv = !bus.o_et | bus.i_rdy;
  assign a_adv = !a_v | b_adv;
  assign bus.o_rdy = a_adv;
  assign bus.o_err_cnt = cnt;
  always_ff @(posedge clk)
    if (rst) begin
      a_v <= 1'b0;
    end else if (a_adv) begin
      a_v  <= bus.i_et;
      a_rl <= bus.i_rl;
      for (int j = 0; j < NSLOT; j++) begin
        a_vl[j] <= bus.i_vl[j];
        a_sl[j] <= '{x: bus.i_x[j], px: bus.i_px[j], s: bus.i_s[j], qh: bus.i_qh[j]};
      end
      for (int k = 1; k <= NLANE; k++) a_ql[k] <= bus.i_ql[k];
    end
  // A lane is in error if it points at an empty slot or shares its slot with a later lane.
  always_comb begin
    err = 1'b0;
    for (int i = 1; i <= NLANE; i++)
      if (a_ql[i] < 4'(NSLOT)) begin
        if (!a_vl[a_ql[i]]) err = 1'b1;
        for (int j = i + 1; j <= NLANE; j++) if (a_ql[j] == a_ql[i]) err = 1'b1;
      end
  end
  for (genvar k = 1; k <= NLANE; k++) begin : g_lane
    lane_gather u_gather (.sl(a_sl), .vl(a_vl), .sel(a_ql[k]), .o(g_sl[k]), .v(g_v[k]));
  end
  always_ff @(posedge clk)
    if (rst) begin
      bus.o_et  <= 1'b0;
      bus.o_err <= 1'b0;
      bus.o_rl  <= '0;
      cnt       <= '0;
      for (int k = 1; k <= NLANE; k++) begin
        bus.o_vl[k] <= 1'b0;
        bus.o_x[k]  <= '0;
        bus.o_px[k] <= '0;
        bus.o_s[k]  <= 1'b0;
        bus.o_qh[k] <= '0;
        bus.o_ql[k] <= QL_NONE;
      end
    end else begin
      if (bus.o_et & bus.i_rdy & bus.o_err & ~&cnt) cnt <= cnt + 1'b1;
      if (b_adv) bus.o_et <= a_v;
      if (b_adv & a_v) begin
        bus.o_err <= err;
        bus.o_rl  <= a_rl;
        for (int k = 1; k <= NLANE; k++) begin
          bus.o_vl[k] <= g_v[k];
          bus.o_x[k]  <= g_sl[k].x;
          bus.o_px[k] <= g_sl[k].px;
          bus.o_s[k]  <= g_sl[k].s;
          bus.o_qh[k] <= g_sl[k].qh;
          bus.o_ql[k] <= a_ql[k];
        end
      end
    end
endmodule
